bootdata_ioctl_bridge: RTL and testbench



---
 rtl/zxdos_ioctl_pkg.sv | 22 ++
 rtl/bootdata_ioctl_bridge_if.sv | 33 +++
 rtl/bootdata_ioctl_bridge.sv | 185 ++++++++++++++++++
 tb/tb_bootdata_ioctl_bridge.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zxdos_ioctl_pkg.sv
// Types and helpers shared by the boot-data to ioctl bridge and its consumers.
package zxdos_ioctl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    BEAT,
    GAP,
    DONE,
    DRAIN
  } state_t;

  localparam logic [2:0] FT_ROM = 3'd0;
  localparam logic [2:0] FT_P   = 3'd1;
  localparam logic [2:0] FT_O   = 3'd2;

  // Bytes carried by one ioctl beat for a given dout MSB index.
  function automatic int bpb(input int dw);
    return (dw + 1) / 8;
  endfunction

endpackage

// File: rtl/bootdata_ioctl_bridge_if.sv
// Host boot-data handshake plus ioctl download bus; slave is the bridge view.
interface bootdata_ioctl_bridge_if #(
  parameter int DW     = 7,
  parameter int SIZE_W = 16,
  parameter int ADDR_W = 27
);
  logic [31:0]       host_bootdata;
  logic              host_bootdata_req;
  logic              host_bootdata_ack;
  logic              host_bootdata_download;
  logic [SIZE_W-1:0] host_bootdata_size;
  logic [2:0]        host_file_type;
  logic              ioctl_download;
  logic [15:0]       ioctl_index;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [DW:0]       ioctl_dout;
  logic              ioctl_wait;

  modport master (
    output host_bootdata, host_bootdata_req, host_bootdata_download,
           host_bootdata_size, host_file_type, ioctl_wait,
    input  host_bootdata_ack, ioctl_download, ioctl_index, ioctl_wr,
           ioctl_addr, ioctl_dout
  );

  modport slave (
    input  host_bootdata, host_bootdata_req, host_bootdata_download,
           host_bootdata_size, host_file_type, ioctl_wait,
    output host_bootdata_ack, ioctl_download, ioctl_index, ioctl_wr,
           ioctl_addr, ioctl_dout
  );
endinterface

// File: rtl/bootdata_ioctl_bridge.sv
// Splits 32-bit boot words into 8/16-bit ioctl beats, truncated at file size; ack 1 cycle after req.
// ioctl_wait stalls the pending beat; WR_GAP idle cycles follow every write strobe.
module bootdata_ioctl_bridge
  import zxdos_ioctl_pkg::*;
#(
  parameter int DW         = 7,
  parameter int WR_GAP     = 3,
  parameter int SIZE_W     = 16,
  parameter int ADDR_W     = 27,
  parameter int INDEX_BASE = 0
) (
  input logic clk_sys,
  input logic reset,
  bootdata_ioctl_bridge_if.slave bus
);

  localparam int                BPB       = bpb(DW);
  localparam logic [1:0]        LAST_BEAT = 2'(4 / BPB - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BPB);
  localparam logic [SIZE_W-1:0] SIZE_STEP = SIZE_W'(BPB);
  localparam logic [3:0]        GAP_LOAD  = 4'((WR_GAP > 0) ? WR_GAP - 1 : 0);

  state_t            state_q, state_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        beat_q, beat_d;
  logic              word_done_q, word_done_d;
  logic [SIZE_W-1:0] rem_q, rem_d;
  logic [3:0]        gap_q, gap_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DW:0]       dout_q, dout_d;
  logic              wr_q, wr_d;
  logic              ack_q, ack_d;
  logic              dl_q, dl_d;
  logic [15:0]       index_q, index_d;
  logic              dl_in_q;

  logic              dl_rise;
  logic [SIZE_W-1:0] take, rem_after;
  logic [DW:0]       beat_dat;

  assign dl_rise   = bus.host_bootdata_download & ~dl_in_q;
  assign take      = (rem_q < SIZE_STEP) ? rem_q : SIZE_STEP;
  assign rem_after = rem_q - take;

  // Bytes beyond the remaining count are zeroed so an odd tail leaves [7:0] clear.
  always_comb begin
    beat_dat = '0;
    for (int j = 0; j < BPB; j++) begin
      if (SIZE_W'(j) < rem_q)
        beat_dat[DW - 8*j -: 8] = word_q[31 - 8*(int'(beat_q)*BPB + j) -: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    beat_d      = beat_q;
    word_done_d = word_done_q;
    rem_d       = rem_q;
    gap_d       = gap_q;
    next_addr_d = next_addr_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    wr_d        = 1'b0;
    ack_d       = 1'b0;
    dl_d        = dl_q;
    index_d     = index_q;

    case (state_q)
      IDLE: begin
        if (dl_rise) begin
          rem_d   = bus.host_bootdata_size;
          index_d = 16'(INDEX_BASE) + 16'(bus.host_file_type);
          if (bus.host_bootdata_size != '0) begin
            dl_d        = 1'b1;
            addr_d      = '0;
            next_addr_d = '0;
            state_d     = FETCH;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      FETCH: begin
        if (!bus.host_bootdata_download) begin
          dl_d    = 1'b0;
          state_d = IDLE;
        end else if (bus.host_bootdata_req && !ack_q) begin
          word_d  = bus.host_bootdata;
          ack_d   = 1'b1;
          beat_d  = '0;
          state_d = BEAT;
        end
      end
      BEAT: begin
        if (!bus.host_bootdata_download) begin
          dl_d    = 1'b0;
          state_d = IDLE;
        end else if (!bus.ioctl_wait) begin
          dout_d      = beat_dat;
          addr_d      = next_addr_q;
          wr_d        = 1'b1;
          rem_d       = rem_after;
          beat_d      = beat_q + 2'd1;
          word_done_d = (beat_q == LAST_BEAT);
          // The last beat skips the gap so ioctl_download drops right after its strobe.
          if (rem_after == '0) begin
            state_d = DONE;
          end else if (WR_GAP == 0) begin
            next_addr_d = next_addr_q + ADDR_STEP;
            state_d     = (beat_q == LAST_BEAT) ? FETCH : BEAT;
          end else begin
            gap_d   = GAP_LOAD;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (!bus.host_bootdata_download) begin
          dl_d    = 1'b0;
          state_d = IDLE;
        end else if (gap_q == '0) begin
          next_addr_d = next_addr_q + ADDR_STEP;
          state_d     = word_done_q ? FETCH : BEAT;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      DONE: begin
        dl_d    = 1'b0;
        state_d = bus.host_bootdata_download ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (!bus.host_bootdata_download)
          state_d = IDLE;
        else if (bus.host_bootdata_req && !ack_q)
          ack_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // dl_in_q follows download through reset so only a fresh rising edge starts a file.
  always_ff @(posedge clk_sys) begin
    dl_in_q <= bus.host_bootdata_download;
    if (reset) begin
      state_q     <= IDLE;
      word_q      <= '0;
      beat_q      <= '0;
      word_done_q <= 1'b0;
      rem_q       <= '0;
      gap_q       <= '0;
      next_addr_q <= '0;
      addr_q      <= '0;
      dout_q      <= '0;
      wr_q        <= 1'b0;
      ack_q       <= 1'b0;
      dl_q        <= 1'b0;
      index_q     <= 16'(INDEX_BASE);
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      beat_q      <= beat_d;
      word_done_q <= word_done_d;
      rem_q       <= rem_d;
      gap_q       <= gap_d;
      next_addr_q <= next_addr_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      wr_q        <= wr_d;
      ack_q       <= ack_d;
      dl_q        <= dl_d;
      index_q     <= index_d;
    end
  end

  assign bus.host_bootdata_ack = ack_q;
  assign bus.ioctl_download    = dl_q;
  assign bus.ioctl_index       = index_q;
  assign bus.ioctl_wr          = wr_q;
  assign bus.ioctl_addr        = addr_q;
  assign bus.ioctl_dout        = dout_q;

endmodule

// File: tb/tb_bootdata_ioctl_bridge.sv
// Byte-mode (WR_GAP=3, INDEX_BASE=0x10) and WIDE-mode (WR_GAP=0) bridges against a write scoreboard.
module tb_bootdata_ioctl_bridge;
  import zxdos_ioctl_pkg::*;

  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  bootdata_ioctl_bridge_if #(.DW(7),  .SIZE_W(16), .ADDR_W(27)) bus_a ();
  bootdata_ioctl_bridge_if #(.DW(15), .SIZE_W(16), .ADDR_W(27)) bus_b ();

  bootdata_ioctl_bridge #(.DW(7), .WR_GAP(3), .SIZE_W(16), .ADDR_W(27), .INDEX_BASE(16))
    u_a (.clk_sys(clk_sys), .reset(reset), .bus(bus_a));
  bootdata_ioctl_bridge #(.DW(15), .WR_GAP(0), .SIZE_W(16), .ADDR_W(27), .INDEX_BASE(0))
    u_b (.clk_sys(clk_sys), .reset(reset), .bus(bus_b));

  typedef struct {
    logic [26:0] addr;
    logic [15:0] dat;
  } exp_t;

  exp_t        exp_a[$], exp_b[$];
  logic [31:0] words_a[$], words_b[$];
  logic        feed_en_a = 1'b1, feed_en_b = 1'b1;
  int          ack_a = 0, ack_b = 0, wr_a = 0, wr_b = 0;
  int          last_wr_a = -100;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic wait_wr_a(input int target, input string tag);
    for (int i = 0; i < 300 && wr_a < target; i++) step();
    check(tag, 64'(wr_a), 64'(target));
  endtask

  task automatic wait_wr_b(input int target, input string tag);
    for (int i = 0; i < 300 && wr_b < target; i++) step();
    check(tag, 64'(wr_b), 64'(target));
  endtask

  // Host side: present queued words one at a time, hold req until acked.
  always @(negedge clk_sys) begin
    if (!feed_en_a) begin
      bus_a.host_bootdata_req = 1'b0;
      words_a.delete();
    end else if (bus_a.host_bootdata_ack) begin
      bus_a.host_bootdata_req = 1'b0;
      ack_a++;
    end else if (!bus_a.host_bootdata_req && words_a.size() > 0) begin
      bus_a.host_bootdata     = words_a.pop_front();
      bus_a.host_bootdata_req = 1'b1;
    end
  end

  always @(negedge clk_sys) begin
    if (!feed_en_b) begin
      bus_b.host_bootdata_req = 1'b0;
      words_b.delete();
    end else if (bus_b.host_bootdata_ack) begin
      bus_b.host_bootdata_req = 1'b0;
      ack_b++;
    end else if (!bus_b.host_bootdata_req && words_b.size() > 0) begin
      bus_b.host_bootdata     = words_b.pop_front();
      bus_b.host_bootdata_req = 1'b1;
    end
  end

  // Consumer side: every strobe must match the next expected write.
  always @(negedge clk_sys) begin
    if (bus_a.ioctl_wr) begin : mon_a
      exp_t e;
      wr_a++;
      check("a_wr_spacing", 64'((cyc - last_wr_a) >= 4), 64'd1);
      last_wr_a = cyc;
      if (exp_a.size() == 0) begin
        check("a_unexpected_wr", 64'd1, 64'd0);
      end else begin
        e = exp_a.pop_front();
        check("a_addr", 64'(bus_a.ioctl_addr), 64'(e.addr));
        check("a_dout", 64'(bus_a.ioctl_dout), 64'(e.dat[7:0]));
      end
    end
  end

  always @(negedge clk_sys) begin
    if (bus_b.ioctl_wr) begin : mon_b
      exp_t e;
      wr_b++;
      if (exp_b.size() == 0) begin
        check("b_unexpected_wr", 64'd1, 64'd0);
      end else begin
        e = exp_b.pop_front();
        check("b_addr", 64'(bus_b.ioctl_addr), 64'(e.addr));
        check("b_dout", 64'(bus_b.ioctl_dout), 64'(e.dat));
      end
    end
  end

  initial begin : stim
    int          base_wr, base_ack;
    logic [26:0] hold_addr;
    logic [7:0]  hold_dout;
    logic        seen_dl;

    reset = 1'b1;
    bus_a.host_bootdata_download = 1'b0;
    bus_a.host_bootdata_size     = '0;
    bus_a.host_file_type         = '0;
    bus_a.ioctl_wait             = 1'b0;
    bus_b.host_bootdata_download = 1'b0;
    bus_b.host_bootdata_size     = '0;
    bus_b.host_file_type         = '0;
    bus_b.ioctl_wait             = 1'b0;
    repeat (3) step();
    check("rst_ack",   64'(bus_a.host_bootdata_ack), 64'd0);
    check("rst_dl",    64'(bus_a.ioctl_download), 64'd0);
    check("rst_wr",    64'(bus_a.ioctl_wr), 64'd0);
    check("rst_addr",  64'(bus_a.ioctl_addr), 64'd0);
    check("rst_dout",  64'(bus_a.ioctl_dout), 64'd0);
    check("rst_index", 64'(bus_a.ioctl_index), 64'h10);
    check("rst_b_index", 64'(bus_b.ioctl_index), 64'd0);
    reset = 1'b0;
    step();

    // Byte mode, 5-byte file across two words.
    base_wr = wr_a; base_ack = ack_a;
    bus_a.host_bootdata_size = 16'd5;
    bus_a.host_file_type     = FT_P;
    words_a.push_back(32'h11223344);
    words_a.push_back(32'h55AAAAAA);
    for (int i = 0; i < 5; i++) exp_a.push_back('{27'(i), 16'(8'h11 * (i + 1))});
    bus_a.host_bootdata_download = 1'b1;
    wait_wr_a(base_wr + 5, "t1_wr_count");
    check("t1_dl_at_last_wr", 64'(bus_a.ioctl_download), 64'd1);
    step();
    check("t1_dl_fall", 64'(bus_a.ioctl_download), 64'd0);
    check("t1_index", 64'(bus_a.ioctl_index), 64'h11);
    repeat (10) step();
    check("t1_no_extra_wr", 64'(wr_a - base_wr), 64'd5);
    check("t1_acks", 64'(ack_a - base_ack), 64'd2);
    check("t1_sb_empty", 64'(exp_a.size()), 64'd0);
    bus_a.host_bootdata_download = 1'b0;
    repeat (2) step();

    // ioctl_wait held for 10 cycles before beat 2.
    base_wr = wr_a;
    bus_a.host_bootdata_size = 16'd4;
    bus_a.host_file_type     = FT_ROM;
    words_a.push_back(32'hDEADBEEF);
    exp_a.push_back('{27'd0, 16'hDE});
    exp_a.push_back('{27'd1, 16'hAD});
    exp_a.push_back('{27'd2, 16'hBE});
    exp_a.push_back('{27'd3, 16'hEF});
    bus_a.host_bootdata_download = 1'b1;
    wait_wr_a(base_wr + 1, "t2_first_wr");
    bus_a.ioctl_wait = 1'b1;
    hold_addr = bus_a.ioctl_addr;
    hold_dout = bus_a.ioctl_dout;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t2_wait_no_wr", 64'(bus_a.ioctl_wr), 64'd0);
      check("t2_wait_addr", 64'(bus_a.ioctl_addr), 64'(hold_addr));
      check("t2_wait_dout", 64'(bus_a.ioctl_dout), 64'(hold_dout));
    end
    bus_a.ioctl_wait = 1'b0;
    step();
    check("t2_resume", 64'(bus_a.ioctl_wr), 64'd1);
    wait_wr_a(base_wr + 4, "t2_wr_count");
    step();
    bus_a.host_bootdata_download = 1'b0;
    repeat (2) step();
    check("t2_sb_empty", 64'(exp_a.size()), 64'd0);

    // Zero-length file: drain three words.
    base_wr = wr_a; base_ack = ack_a; seen_dl = 1'b0;
    bus_a.host_bootdata_size = 16'd0;
    bus_a.host_bootdata_download = 1'b1;
    for (int i = 0; i < 3; i++) words_a.push_back(32'hC0DE0000 + 32'(i));
    for (int i = 0; i < 40; i++) begin
      step();
      seen_dl = seen_dl | bus_a.ioctl_download;
    end
    check("t3_acks", 64'(ack_a - base_ack), 64'd3);
    check("t3_no_dl", 64'(seen_dl), 64'd0);
    check("t3_no_wr", 64'(wr_a - base_wr), 64'd0);
    bus_a.host_bootdata_download = 1'b0;
    repeat (2) step();

    // Download dropped after two beats, then a fresh file.
    base_wr = wr_a;
    bus_a.host_bootdata_size = 16'd16;
    bus_a.host_file_type     = FT_O;
    for (int i = 0; i < 4; i++) words_a.push_back(32'h01020304 * 32'(i + 1));
    exp_a.push_back('{27'd0, 16'h01});
    exp_a.push_back('{27'd1, 16'h02});
    bus_a.host_bootdata_download = 1'b1;
    wait_wr_a(base_wr + 2, "t4_two_beats");
    bus_a.host_bootdata_download = 1'b0;
    step();
    check("t4_dl_drop", 64'(bus_a.ioctl_download), 64'd0);
    repeat (20) step();
    check("t4_no_more_wr", 64'(wr_a - base_wr), 64'd2);
    feed_en_a = 1'b0;
    step();
    feed_en_a = 1'b1;
    bus_a.host_bootdata_size = 16'd2;
    bus_a.host_file_type     = 3'd3;
    words_a.push_back(32'h77880000);
    exp_a.push_back('{27'd0, 16'h77});
    exp_a.push_back('{27'd1, 16'h88});
    bus_a.host_bootdata_download = 1'b1;
    wait_wr_a(base_wr + 4, "t4_restart");
    check("t4_new_index", 64'(bus_a.ioctl_index), 64'h13);
    step();
    bus_a.host_bootdata_download = 1'b0;
    repeat (2) step();

    // Reset during GAP with the next word's req already pending.
    base_wr = wr_a;
    bus_a.host_bootdata_size = 16'd8;
    bus_a.host_file_type     = FT_P;
    words_a.push_back(32'h01020304);
    words_a.push_back(32'h05060708);
    exp_a.push_back('{27'd0, 16'h01});
    bus_a.host_bootdata_download = 1'b1;
    wait_wr_a(base_wr + 1, "t5_first_wr");
    reset = 1'b1;
    step();
    check("t5_rst_ack",   64'(bus_a.host_bootdata_ack), 64'd0);
    check("t5_rst_dl",    64'(bus_a.ioctl_download), 64'd0);
    check("t5_rst_wr",    64'(bus_a.ioctl_wr), 64'd0);
    check("t5_rst_addr",  64'(bus_a.ioctl_addr), 64'd0);
    check("t5_rst_dout",  64'(bus_a.ioctl_dout), 64'd0);
    check("t5_rst_index", 64'(bus_a.ioctl_index), 64'h10);
    reset = 1'b0;
    base_ack = ack_a;
    repeat (8) step();
    check("t5_held_req_no_ack", 64'(ack_a - base_ack), 64'd0);
    check("t5_no_wr", 64'(wr_a - base_wr), 64'd1);
    bus_a.host_bootdata_download = 1'b0;
    step();
    bus_a.host_bootdata_size = 16'd4;
    bus_a.host_file_type     = FT_O;
    for (int i = 0; i < 4; i++) exp_a.push_back('{27'(i), 16'(5 + i)});
    bus_a.host_bootdata_download = 1'b1;
    wait_wr_a(base_wr + 5, "t5_new_file");
    check("t5_held_req_acked", 64'(ack_a - base_ack), 64'd1);
    step();
    bus_a.host_bootdata_download = 1'b0;
    repeat (2) step();
    check("t5_sb_empty", 64'(exp_a.size()), 64'd0);

    // WIDE mode, odd size.
    base_wr = wr_b; base_ack = ack_b;
    bus_b.host_bootdata_size = 16'd3;
    bus_b.host_file_type     = FT_O;
    words_b.push_back(32'hA1B2C3D4);
    exp_b.push_back('{27'd0, 16'hA1B2});
    exp_b.push_back('{27'd2, 16'hC300});
    bus_b.host_bootdata_download = 1'b1;
    wait_wr_b(base_wr + 2, "t6_wr_count");
    step();
    check("t6_dl_fall", 64'(bus_b.ioctl_download), 64'd0);
    check("t6_acks", 64'(ack_b - base_ack), 64'd1);
    check("t6_index", 64'(bus_b.ioctl_index), 64'd2);
    bus_b.host_bootdata_download = 1'b0;
    repeat (2) step();

    // WIDE mode across a word boundary with no gap.
    base_wr = wr_b; base_ack = ack_b;
    bus_b.host_bootdata_size = 16'd6;
    bus_b.host_file_type     = FT_ROM;
    words_b.push_back(32'h01020304);
    words_b.push_back(32'h05060000);
    exp_b.push_back('{27'd0, 16'h0102});
    exp_b.push_back('{27'd2, 16'h0304});
    exp_b.push_back('{27'd4, 16'h0506});
    bus_b.host_bootdata_download = 1'b1;
    wait_wr_b(base_wr + 3, "t7_wr_count");
    repeat (5) step();
    check("t7_acks", 64'(ack_b - base_ack), 64'd2);
    check("t7_no_extra_wr", 64'(wr_b - base_wr), 64'd3);
    check("t7_sb_empty", 64'(exp_b.size()), 64'd0);
    bus_b.host_bootdata_download = 1'b0;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
